// File: rtl/famicom_ppu_bus_pkg.sv
// Shared types for the PPU bus sequencer: bus FSM states, mirroring modes
// and requester IDs.
package famicom_ppu_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ALE  = 2'd1,
      ST_STB1 = 2'd2,
      ST_STB2 = 2'd3
   } bus_state_t;

   localparam int MIRROR_H = 0;
   localparam int MIRROR_V = 1;

   typedef enum logic {
      REQ_REND = 1'b0,
      REQ_CPU  = 1'b1
   } req_id_t;

endpackage

// File: rtl/famicom_ppu_bus_seq_arb.sv
// Requester arbitration for the PPU bus.
// Render has priority, but a streak counter forces a CPU win after CPU_SLOT
// consecutive render grants made while the CPU was waiting.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   decide              1 on a decision edge (FSM in IDLE or STB2)
//   rend_req, cpu_req   pending requests
//   win_id, win_valid   winner and "someone requests", valid when decide=1
module famicom_ppu_bus_arb
   import famicom_ppu_bus_pkg::*;
#(
   parameter int CPU_SLOT = 8
) (
   input  logic    CLK,
   input  logic    RST,
   input  logic    decide,
   input  logic    rend_req,
   input  logic    cpu_req,
   output req_id_t win_id,
   output logic    win_valid
);

   logic [3:0] streak_q, streak_d;
   logic       cpu_wins;

   always_comb begin
      cpu_wins  = cpu_req && (!rend_req || (streak_q == 4'(CPU_SLOT)));
      win_valid = rend_req || cpu_req;
      win_id    = cpu_wins ? REQ_CPU : REQ_REND;
      streak_d  = streak_q;
      if (decide) begin
         // Only render grants made while the CPU waits count toward the streak.
         if (!cpu_req || cpu_wins) streak_d = 4'd0;
         else                      streak_d = streak_q + 4'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) streak_q <= 4'd0;
      else     streak_q <= streak_d;
   end

endmodule

// File: rtl/famicom_ppu_bus_seq.sv
// PPU-side bus sequencer: arbitrates render fetches and CPU $2007 accesses
// and drives the multiplexed PPU bus (ALE/AD/PA/nRD/nWE) plus the nametable
// SRAM chip select and mirrored A10.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   rend_req/addr, rend_gnt/done   render read port
//   cpu_req/we/addr/wdata,
//   cpu_gnt/done                   CPU data port
//   rd_data                        read data, valid with a done pulse
//   ALE, PA_hi, AD_out, AD_oe,
//   AD_in, nRD, nWE                multiplexed PPU bus
//   nVRAM_CS, VRAM_A10             nametable SRAM select and A10
//
// state   | meaning
// IDLE    | bus quiet, waiting for a request (decision edge)
// ALE     | address on AD/PA, latch enable high, grant pulse
// STB1    | first strobe cycle (nRD or nWE low)
// STB2    | second strobe cycle, read data sampled, decision edge
module famicom_ppu_bus_seq
   import famicom_ppu_bus_pkg::*;
#(
   parameter int MIRROR   = 0,
   parameter int CPU_SLOT = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        rend_req,
   input  logic [13:0] rend_addr,
   output logic        rend_gnt,
   output logic        rend_done,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [13:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_done,
   output logic [7:0]  rd_data,
   output logic        ALE,
   output logic [5:0]  PA_hi,
   output logic [7:0]  AD_out,
   output logic        AD_oe,
   input  logic [7:0]  AD_in,
   output logic        nRD,
   output logic        nWE,
   output logic        nVRAM_CS,
   output logic        VRAM_A10
);

   bus_state_t  state_q, state_d;
   logic [13:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [7:0]  wdata_q, wdata_d;
   req_id_t     id_q, id_d;
   logic        rend_done_q, rend_done_d;
   logic        cpu_done_q, cpu_done_d;
   logic [7:0]  rd_data_q, rd_data_d;

   logic        decide;
   logic        win_valid;
   req_id_t     win_id;
   logic        active;

   assign decide = (state_q == ST_IDLE) || (state_q == ST_STB2);

   famicom_ppu_bus_arb #(.CPU_SLOT(CPU_SLOT)) u_arb (
      .CLK       (CLK),
      .RST       (RST),
      .decide    (decide),
      .rend_req  (rend_req),
      .cpu_req   (cpu_req),
      .win_id    (win_id),
      .win_valid (win_valid)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      id_d        = id_q;
      rd_data_d   = rd_data_q;
      rend_done_d = 1'b0;
      cpu_done_d  = 1'b0;

      if (state_q == ST_STB2) begin
         rend_done_d = (id_q == REQ_REND);
         cpu_done_d  = (id_q == REQ_CPU);
         if (!we_q) rd_data_d = AD_in;
      end

      unique case (state_q)
         ST_ALE:  state_d = ST_STB1;
         ST_STB1: state_d = ST_STB2;
         default: state_d = win_valid ? ST_ALE : ST_IDLE;
      endcase

      // Render is read-only, so its captured we/wdata are forced to a read.
      if (decide && win_valid) begin
         id_d    = win_id;
         addr_d  = (win_id == REQ_CPU) ? cpu_addr : rend_addr;
         we_d    = (win_id == REQ_CPU) && cpu_we;
         wdata_d = (win_id == REQ_CPU) ? cpu_wdata : 8'h00;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         id_q        <= REQ_REND;
         rend_done_q <= 1'b0;
         cpu_done_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         id_q        <= id_d;
         rend_done_q <= rend_done_d;
         cpu_done_q  <= cpu_done_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign active = (state_q != ST_IDLE);

   always_comb begin
      ALE      = 1'b0;
      AD_oe    = 1'b0;
      AD_out   = 8'h00;
      PA_hi    = 6'h00;
      nRD      = 1'b1;
      nWE      = 1'b1;
      nVRAM_CS = 1'b1;
      VRAM_A10 = 1'b0;
      rend_gnt = (state_q == ST_ALE) && (id_q == REQ_REND);
      cpu_gnt  = (state_q == ST_ALE) && (id_q == REQ_CPU);
      if (active) begin
         PA_hi    = addr_q[13:8];
         nVRAM_CS = ~addr_q[13];
         VRAM_A10 = (MIRROR == MIRROR_V) ? addr_q[10] : addr_q[11];
      end
      if (state_q == ST_ALE) begin
         ALE    = 1'b1;
         AD_oe  = 1'b1;
         AD_out = addr_q[7:0];
      end else if (active) begin
         AD_oe  = we_q;
         AD_out = we_q ? wdata_q : 8'h00;
         nRD    = we_q;
         nWE    = ~we_q;
      end
   end

   assign rend_done = rend_done_q;
   assign cpu_done  = cpu_done_q;
   assign rd_data   = rd_data_q;

endmodule
